fft_stage_ctrl: RTL and testbench

Sequencer for the two-pass 16-point FFT datapath. It accepts four 4-point input beats, steers them through the butterfly into the 16-entry transpose buffer, and waits for the buffer to turn around. It then replays the transposed beats through the butterfly with twiddle indices and flags valid output beats. It sits between the frame source and the butterfly/buffer/MUX-DEMUX datapath and owns every control strobe of that datapath.

---
 rtl/fft_stage_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: control sequencer for the two-pass 16-point FFT datapath.
// Define FFT_CTRL_ERR_EN to build the sticky err_ovr protocol-error flag.
module fft_stage_ctrl #(
    parameter int BF_LAT   = 1,
    parameter int TURN_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       bf_src_sel,
    output logic       demux_sel,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [1:0] twiddle_idx,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic       err_ovr
);

    localparam int WAIT_CYC  = BF_LAT + TURN_CYC;
    localparam int FLUSH_CYC = BF_LAT + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BF_LAT-1:0] wr_dly_q, wr_dly_d;
    logic [BF_LAT:0]   rd_dly_q, rd_dly_d;
    logic              accept;

    // Strobes decoded purely from the registered state.
    always_comb begin
        in_ready    = (state_q == S_LOAD);
        bf_src_sel  = (state_q == S_WAIT) || (state_q == S_DRAIN)
                   || (state_q == S_FLUSH);
        demux_sel   = (state_q == S_DRAIN) || (state_q == S_FLUSH);
        reg_rd_en   = (state_q == S_DRAIN);
        twiddle_idx = (state_q == S_DRAIN) ? beat_q : 2'd0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        accept      = in_valid && (state_q == S_LOAD);
        reg_wr_en   = wr_dly_q[BF_LAT-1];
        out_valid   = rd_dly_q[BF_LAT];
    end

    // Frame sequencing: load four beats, turn around, drain four beats, flush.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    beat_d  = 2'd0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_CYC - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = 4'd0;
                    beat_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = S_FLUSH;
                    cnt_d   = 4'd0;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 4'(FLUSH_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Delay lines tracking beats through the butterfly and the buffer read.
    always_comb begin
        wr_dly_d    = wr_dly_q << 1;
        wr_dly_d[0] = accept;
        rd_dly_d    = rd_dly_q << 1;
        rd_dly_d[0] = (state_q == S_DRAIN);
    end

    // State, counters and delay lines; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= 2'd0;
            cnt_q    <= 4'd0;
            wr_dly_q <= '0;
            rd_dly_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            wr_dly_q <= wr_dly_d;
            rd_dly_q <= rd_dly_d;
        end
    end

`ifdef FFT_CTRL_ERR_EN
    logic err_q, err_d;

    // Sticky misuse flag; a fresh accepted start clears it.
    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && start) begin
            err_d = 1'b0;
        end else if ((start && (state_q != S_IDLE))
                  || (in_valid && bf_src_sel)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_ovr = err_q;
`else
    assign err_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl, two parameter sets side by side.
// Honours FFT_CTRL_ERR_EN when the design is built with it.
`timescale 1ns/1ps
module tb_fft_stage_ctrl;

    localparam int LIMIT = 4000;
    localparam int NONE  = -100;
    localparam int INF   = 1000000;
`ifdef FFT_CTRL_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct {
        int g;
        int k;
        int c;
        int idx;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rst, start, in_valid;
    logic [1:0] in_ready, bf_src_sel, demux_sel, reg_wr_en, reg_rd_en;
    logic [1:0] out_valid, busy, done, err_ovr;
    logic [1:0] tw0, tw1;

    fft_stage_ctrl #(.BF_LAT(1), .TURN_CYC(2)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .bf_src_sel(bf_src_sel[0]),
        .demux_sel(demux_sel[0]), .reg_wr_en(reg_wr_en[0]),
        .reg_rd_en(reg_rd_en[0]), .twiddle_idx(tw0),
        .out_valid(out_valid[0]), .busy(busy[0]), .done(done[0]),
        .err_ovr(err_ovr[0])
    );

    fft_stage_ctrl #(.BF_LAT(3), .TURN_CYC(1)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .bf_src_sel(bf_src_sel[1]),
        .demux_sel(demux_sel[1]), .reg_wr_en(reg_wr_en[1]),
        .reg_rd_en(reg_rd_en[1]), .twiddle_idx(tw1),
        .out_valid(out_valid[1]), .busy(busy[1]), .done(done[1]),
        .err_ovr(err_ovr[1])
    );

    ev_t sb[$];
    int  ls[2], le[2], dr[2], dn[2], ef[2], eu[2];
    bit  mon_en  = 1'b0;
    bit  fin_req = 1'b0;
    int  n_pass  = 0;
    int  n_tot   = 0;

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int trn(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic string kname(input int k);
        case (k)
            0: return "reg_wr_en";
            1: return "reg_rd_en";
            2: return "out_valid";
            default: return "done";
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic err_ev(input int g, input int c);
        if (!(ef[g] <= c + 1 && eu[g] > c + 1)) begin
            ef[g] = c + 1;
            eu[g] = INF;
        end
    endtask

    // mode 0: back-to-back beats, 1: fixed gaps, 2: random gaps,
    // 3: back-to-back with reset on the second drain beat
    task automatic frame(input int g, input int mode, input bit junk,
                         input bit b2b);
        int s, p, gap, w, d, e;
        int a[4];
        s = cyc;
        p = s;
        for (int i = 0; i < 4; i++) begin
            if (mode == 1) gap = (i == 1) ? 1 : ((i == 2) ? 2 : 0);
            else if (mode == 2) gap = $urandom_range(0, 3);
            else gap = 0;
            p = p + 1 + gap;
            a[i] = p;
        end
        w = a[3] + 1;
        d = w + lat(g) + trn(g);
        e = d + 4 + lat(g) + 1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{g: g, k: 0, c: a[i] + lat(g), idx: 0});
            sb.push_back('{g: g, k: 1, c: d + i, idx: i});
            sb.push_back('{g: g, k: 2, c: d + i + 1 + lat(g), idx: 0});
        end
        sb.push_back('{g: g, k: 3, c: e, idx: 0});
        ls[g] = s + 1;
        le[g] = a[3];
        dr[g] = d;
        dn[g] = e;
        if (ef[g] <= s && eu[g] > s + 1) eu[g] = s + 1;
        start[g] = 1'b1;
        step();
        start[g] = 1'b0;
        while (cyc <= a[3]) begin
            in_valid[g] = (cyc == a[0]) || (cyc == a[1])
                       || (cyc == a[2]) || (cyc == a[3]);
            step();
        end
        in_valid[g] = 1'b0;
        if (mode == 3) begin
            while (cyc < d + 1) step();
            rst[g] = 1'b1;
            step();
            rst[g] = 1'b0;
            for (int j = sb.size() - 1; j >= 0; j--)
                if (sb[j].g == g && sb[j].c > d + 1) sb.delete(j);
            le[g] = NONE;
            dn[g] = NONE;
            if (eu[g] > cyc) eu[g] = cyc;
        end else begin
            while (cyc <= e) begin
                start[g] = 1'b0;
                in_valid[g] = 1'b0;
                if (junk && $urandom_range(0, 5) == 0) begin
                    start[g] = 1'b1;
                    err_ev(g, cyc);
                end
                if (junk && cyc >= w && cyc < e
                    && $urandom_range(0, 5) == 0) begin
                    in_valid[g] = 1'b1;
                    err_ev(g, cyc);
                end
                if (b2b && cyc == e) begin
                    start[g] = 1'b1;
                    err_ev(g, cyc);
                end
                step();
            end
            start[g] = 1'b0;
            in_valid[g] = 1'b0;
            if (!b2b) repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic run(input int g);
        frame(g, 0, 1'b0, 1'b0);
        frame(g, 1, 1'b0, 1'b1);
        frame(g, 0, 1'b0, 1'b0);
        frame(g, 3, 1'b0, 1'b0);
        frame(g, 0, 1'b0, 1'b0);
        repeat (8) frame(g, 2, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst = 2'b11;
        start = 2'b00;
        in_valid = 2'b00;
        for (int g = 0; g < 2; g++) begin
            ls[g] = NONE;
            le[g] = NONE;
            dr[g] = NONE;
            dn[g] = NONE;
            ef[g] = INF;
            eu[g] = INF;
        end
        step();
        mon_en = 1'b1;
        step();
        rst = 2'b00;
        fork
            run(0);
            run(1);
        join
        step();
        step();
        fin_req = 1'b1;
    end

    // Monitor: match strobes against the scoreboard, check level outputs.
    always @(negedge clk) begin : mon
        logic [3:0] obs;
        logic [4:0] exp_l, act_l;
        logic [1:0] twv;
        bit found, ok;
        int j;
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                obs = {done[g], out_valid[g], reg_rd_en[g], reg_wr_en[g]};
                twv = (g == 0) ? tw0 : tw1;
                for (int k = 0; k < 4; k++) begin
                    if (obs[k]) begin
                        found = 1'b0;
                        ok = 1'b0;
                        j = 0;
                        while (j < sb.size() && !found) begin
                            if (sb[j].g == g && sb[j].k == k
                                && sb[j].c == cyc) begin
                                found = 1'b1;
                                ok = (k != 1) || (twv == 2'(sb[j].idx));
                                if (!ok)
                                    $display("FAIL twiddle dut%0d cyc %0d: got %0d required %0d",
                                             g, cyc, twv, sb[j].idx);
                                sb.delete(j);
                            end else begin
                                j++;
                            end
                        end
                        n_tot++;
                        if (ok) n_pass++;
                        else if (!found)
                            $display("FAIL %s dut%0d cyc %0d: got pulse, required none",
                                     kname(k), g, cyc);
                    end
                end
                j = 0;
                while (j < sb.size()) begin
                    if (sb[j].g == g && sb[j].c <= cyc) begin
                        n_tot++;
                        $display("FAIL %s dut%0d cyc %0d: got no pulse, required at %0d",
                                 kname(sb[j].k), g, cyc, sb[j].c);
                        sb.delete(j);
                    end else begin
                        j++;
                    end
                end
                exp_l = {cyc >= ls[g] && cyc <= dn[g],
                         cyc >= ls[g] && cyc <= le[g],
                         cyc > le[g] && cyc < dn[g],
                         cyc >= dr[g] && cyc < dn[g],
                         ERR_ON && cyc >= ef[g] && cyc < eu[g]};
                act_l = {busy[g], in_ready[g], bf_src_sel[g],
                         demux_sel[g], err_ovr[g]};
                n_tot++;
                if (act_l === exp_l) n_pass++;
                else
                    $display("FAIL levels dut%0d cyc %0d: got %b required %b (busy,rdy,src,demux,err)",
                             g, cyc, act_l, exp_l);
            end
        end
        if (fin_req || cyc > LIMIT) begin
            if (cyc > LIMIT) begin
                n_tot++;
                $display("FAIL timeout cyc %0d: got no finish, required by %0d",
                         cyc, LIMIT);
            end
            while (sb.size() > 0) begin
                n_tot++;
                $display("FAIL %s dut%0d: got no pulse, required at %0d",
                         kname(sb[0].k), sb[0].g, sb[0].c);
                sb.delete(0);
            end
            $display("%0d/%0d checks passed", n_pass, n_tot);
            $finish;
        end
    end

endmodule
